// File: rtl/hamming_ecc_pkg.sv
// Shared Hamming(7,4) definitions: widths, position type, encoder helpers
// and the state encoding of the skid buffer.
package hamming_ecc_pkg;

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;

  // Codeword position index, 1..7 (0 means "no position").
  typedef logic [2:0] pos_t;

  // Skid buffer state, encoded as {skid_v, out_v}.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // Encode d[3]=d1 .. d[0]=d4 into {p1,p2,d1,p4,d2,d3,d4} (position 1 is the MSB).
  // The decoder's syndrome bits are defined over exactly these parity groups.
  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] d);
    logic d1, d2, d3, d4, p1, p2, p4;
    d1 = d[3];
    d2 = d[2];
    d3 = d[1];
    d4 = d[0];
    p1 = d1 ^ d2 ^ d4;
    p2 = d1 ^ d3 ^ d4;
    p4 = d2 ^ d3 ^ d4;
    return {p1, p2, d1, p4, d2, d3, d4};
  endfunction

  // One-hot mask selecting codeword position pos (position 1 = bit 6); 0 gives no bit.
  function automatic logic [CODE_W-1:0] pos_mask(input pos_t pos);
    logic [CODE_W-1:0] m;
    case (pos)
      3'd1:    m = 7'b1000000;
      3'd2:    m = 7'b0100000;
      3'd3:    m = 7'b0010000;
      3'd4:    m = 7'b0001000;
      3'd5:    m = 7'b0000100;
      3'd6:    m = 7'b0000010;
      3'd7:    m = 7'b0000001;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hamming_ecc_skid.sv
// Two-entry skid buffer (OUT register plus one SKID register) with a
// registered in_ready taken straight from the state, so there is no
// combinational path from out_ready to in_ready.
module hamming_ecc_skid
  import hamming_ecc_pkg::*;
#(
  parameter int unsigned W = CODE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e  state_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         in_xfer_s;
  logic         out_xfer_s;

  assign in_ready  = ~state_q[1];
  assign out_valid = state_q[0];
  assign out_data  = out_q;

  // Handshake qualifiers for this cycle.
  always_comb begin
    in_xfer_s  = in_valid && in_ready;
    out_xfer_s = out_valid && out_ready;
  end

  // Buffer state machine: routes accepted words into OUT or SKID, refills OUT from SKID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (in_xfer_s) begin
            out_q   <= in_data;
            state_q <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            out_q <= in_data;
          end else if (in_xfer_s) begin
            skid_q  <= in_data;
            state_q <= SKID_FULL;
          end else if (out_xfer_s) begin
            state_q <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_xfer_s) begin
            out_q   <= skid_q;
            state_q <= SKID_ONE;
          end
        end
        default: begin
          state_q <= SKID_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/hamming_ecc_encoder.sv
// Streaming Hamming(7,4) encoder: encodes each accepted data word and queues
// the codeword through a skid buffer; counts codewords taken downstream.
// Optional single-bit error injection is built when the macro
// HAMMING_ECC_ENCODER_ERR_INJECT_EN is defined.
module hamming_ecc_encoder
  import hamming_ecc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [6:0]        out_code,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef HAMMING_ECC_ENCODER_ERR_INJECT_EN
  input  logic              inj_valid,
  input  logic [2:0]        inj_pos,
`endif
  output logic [CNT_W-1:0]  word_cnt
);

  logic [CODE_W-1:0] code_s;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  word_cnt_d;

`ifdef HAMMING_ECC_ENCODER_ERR_INJECT_EN
  pos_t arm_pos_q;
  pos_t arm_pos_d;
  pos_t flip_pos_s;
  logic arm_req_s;

  // Encode, apply a pending (or same-cycle) flip, and track the armed position.
  always_comb begin
    arm_req_s  = inj_valid && (inj_pos != 3'd0);
    flip_pos_s = arm_req_s ? inj_pos : arm_pos_q;
    code_s     = hamming_encode(in_data) ^ pos_mask(flip_pos_s);
    if (in_valid && in_ready) begin
      arm_pos_d = 3'd0;
    end else if (arm_req_s) begin
      arm_pos_d = inj_pos;
    end else begin
      arm_pos_d = arm_pos_q;
    end
  end

  // Armed injection position; zero means disarmed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_pos_q <= 3'd0;
    end else begin
      arm_pos_q <= arm_pos_d;
    end
  end
`else
  // Clean encoding of the incoming word.
  always_comb begin
    code_s = hamming_encode(in_data);
  end
`endif

  hamming_ecc_skid #(
    .W (CODE_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (code_s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Next count: one more per codeword taken downstream, wrapping naturally.
  always_comb begin
    if (out_valid && out_ready) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // Delivered-codeword counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

endmodule
